// File: rtl/cbus_arbiter.sv
// Arbitrates the unified cbus between the fetch (ibus) and data (dbus) ports.
// Optional statistics counters are enabled by defining CBUS_ARB_STAT_EN.
module cbus_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
`ifdef CBUS_ARB_STAT_EN
    ,
    output logic [31:0] stat_igrant,
    output logic [31:0] stat_dgrant,
    output logic [31:0] stat_iwait
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DSTREAK);

    state_t      r_state;
    owner_t      r_owner;
    logic [3:0]  r_streak;
    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;

    logic w_grant_i;
    logic w_grant_d;
    logic w_done;
    logic w_i_done;
    logic w_d_done;

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            // Fetch only beats data once data has won MAX_DSTREAK times in a row.
            w_grant_i = ireq_valid && (!dreq_valid || (r_streak >= MAX_STREAK));
            w_grant_d = dreq_valid && !w_grant_i;
        end
    end

    // A completion racing a reset is dropped, so no data_ok escapes.
    assign w_done   = (r_state == BUSY) && cresp_ready && cresp_last && !reset;
    assign w_i_done = w_done && (r_owner == OWN_I);
    assign w_d_done = w_done && (r_owner == OWN_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= OWN_NONE;
            r_streak <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state  <= BUSY;
                        r_owner  <= OWN_I;
                        r_addr   <= ireq_addr;
                        r_size   <= 3'b010;
                        r_strobe <= '0;
                        r_data   <= '0;
                        r_streak <= '0;
                    end else if (w_grant_d) begin
                        r_state  <= BUSY;
                        r_owner  <= OWN_D;
                        r_addr   <= dreq_addr;
                        r_size   <= dreq_size;
                        r_strobe <= dreq_strobe;
                        r_data   <= dreq_data;
                        if (!ireq_valid)
                            r_streak <= '0;
                        else if (r_streak != 4'hF)
                            r_streak <= r_streak + 4'd1;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign creq_valid    = (r_state == BUSY);
    assign creq_is_write = creq_valid && (r_strobe != 8'h00);
    assign creq_size     = r_size;
    assign creq_addr     = r_addr;
    assign creq_strobe   = r_strobe;
    assign creq_data     = r_data;

    assign iresp_addr_ok = w_i_done;
    assign iresp_data_ok = w_i_done;
    assign iresp_data    = !w_i_done ? 32'h0 :
                           (r_addr[2] ? cresp_data[63:32] : cresp_data[31:0]);

    assign dresp_addr_ok = w_d_done;
    assign dresp_data_ok = w_d_done;
    assign dresp_data    = w_d_done ? cresp_data : 64'h0;

`ifdef CBUS_ARB_STAT_EN
    logic [31:0] r_stat_igrant;
    logic [31:0] r_stat_dgrant;
    logic [31:0] r_stat_iwait;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_igrant <= '0;
            r_stat_dgrant <= '0;
            r_stat_iwait  <= '0;
        end else begin
            if (w_grant_i)
                r_stat_igrant <= r_stat_igrant + 32'd1;
            if (w_grant_d)
                r_stat_dgrant <= r_stat_dgrant + 32'd1;
            if (ireq_valid && !w_i_done)
                r_stat_iwait <= r_stat_iwait + 32'd1;
        end
    end

    assign stat_igrant = r_stat_igrant;
    assign stat_dgrant = r_stat_dgrant;
    assign stat_iwait  = r_stat_iwait;
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: directed requests, a cbus responder model,
// and a monitor that checks every cbus request and every completion in order.
`timescale 1ns/1ps
module tb_cbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready, cresp_last;
    logic [63:0] cresp_data;
`ifdef CBUS_ARB_STAT_EN
    logic [31:0] stat_igrant, stat_dgrant, stat_iwait;
`endif

    cbus_arbiter #(.MAX_DSTREAK(4)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
`ifdef CBUS_ARB_STAT_EN
        , .stat_igrant(stat_igrant), .stat_dgrant(stat_dgrant), .stat_iwait(stat_iwait)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_i;
        logic [63:0] data;
    } rsp_t;

    typedef struct {
        logic        w;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } creq_t;

    rsp_t        q_exp[$];
    creq_t       q_creq[$];
    logic [63:0] q_rsp[$];

    int n_partial   = 0;
    int busy_cycles = 0;
    int done_cyc    = 0;
    int last_gap    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_i(input logic [63:0] a, input logic [63:0] rsp, input logic [31:0] exp_word);
        q_creq.push_back('{w: 1'b0, size: 3'b010, addr: a, strb: 8'h00, wdata: 64'h0});
        q_rsp.push_back(rsp);
        q_exp.push_back('{is_i: 1'b1, data: {32'h0, exp_word}});
    endtask

    task automatic push_d(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                          input logic [63:0] wd, input logic [63:0] rsp);
        q_creq.push_back('{w: (st != 8'h00), size: sz, addr: a, strb: st, wdata: wd});
        q_rsp.push_back(rsp);
        q_exp.push_back('{is_i: 1'b0, data: rsp});
    endtask

    // cbus responder: optional non-final beats, then a final beat carrying queued data.
    initial begin
        int cnt;
        cnt = 0;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (creq_valid) begin
                if (cnt < n_partial) begin
                    cresp_ready = 1'b1;
                    cresp_last  = 1'b0;
                    cresp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
                end else if (cnt == n_partial) begin
                    cresp_ready = 1'b1;
                    cresp_last  = 1'b1;
                    cresp_data  = (q_rsp.size() != 0) ? q_rsp.pop_front() : 64'h0;
                end else begin
                    cresp_ready = 1'b0;
                    cresp_last  = 1'b0;
                    cresp_data  = '0;
                end
                cnt++;
            end else begin
                cresp_ready = 1'b0;
                cresp_last  = 1'b0;
                cresp_data  = '0;
                cnt = 0;
            end
        end
    end

    // Monitor: checks cbus requests when they appear and completions when they occur.
    initial begin
        logic  prev_cv;
        creq_t cur;
        rsp_t  e;
        prev_cv = 1'b0;
        cur = '{w: 1'b0, size: 3'b0, addr: 64'h0, strb: 8'h0, wdata: 64'h0};
        forever begin
            @(negedge clk);
            if (creq_valid) busy_cycles++;
            if (creq_valid && !prev_cv) begin
                last_gap = cyc - done_cyc;
                if (q_creq.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL creq_unexpected: got addr %h expected no request", creq_addr);
                end else begin
                    cur = q_creq.pop_front();
                    check("creq_addr", creq_addr, cur.addr);
                    check("creq_ctl", {creq_is_write, creq_size, creq_strobe},
                          {cur.w, cur.size, cur.strb});
                    check("creq_data", creq_data, cur.wdata);
                end
            end else if (creq_valid) begin
                check("creq_stable_addr", creq_addr, cur.addr);
                check("creq_stable_ctl", {creq_is_write, creq_size, creq_strobe},
                      {cur.w, cur.size, cur.strb});
                check("creq_stable_data", creq_data, cur.wdata);
            end
            prev_cv = creq_valid;

            if (iresp_data_ok || dresp_data_ok) begin
                done_cyc = cyc;
                if (q_exp.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL rsp_unexpected: got i_ok=%0b d_ok=%0b expected none",
                             iresp_data_ok, dresp_data_ok);
                end else begin
                    e = q_exp.pop_front();
                    check("rsp_owner", {iresp_data_ok, dresp_data_ok}, {e.is_i, !e.is_i});
                    check("rsp_addr_ok", {iresp_addr_ok, dresp_addr_ok}, {e.is_i, !e.is_i});
                    if (e.is_i) check("iresp_data", {32'h0, iresp_data}, e.data);
                    else        check("dresp_data", dresp_data, e.data);
                end
            end
        end
    end

    task automatic wait_ok(input bit is_i, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (is_i ? iresp_data_ok : dresp_data_ok) break;
            n++;
            if (n > 60) begin
                checks++; errs++;
                $display("FAIL %s_timeout: got no data_ok expected one within 60 cycles", name);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ireq_op(input logic [63:0] a);
        ireq_valid = 1'b1;
        ireq_addr  = a;
        wait_ok(1'b1, "fetch");
        ireq_valid = 1'b0;
    endtask

    task automatic dreq_op(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                           input logic [63:0] wd);
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_size   = sz;
        dreq_strobe = st;
        dreq_data   = wd;
        wait_ok(1'b0, "data");
        dreq_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc;
        int n;
        reset = 1'b1;
        ireq_valid = 0; ireq_addr = 0;
        dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_creq_valid", {63'h0, creq_valid}, 64'h0);
        check("rst_oks", {60'h0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'h0);
        check("rst_creq_addr", creq_addr, 64'h0);
        check("rst_creq_ctl", {52'h0, creq_is_write, creq_size, creq_strobe}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single fetch: upper word selected by addr[2], data_ok one cycle after grant.
        push_i(64'h8000_0004, 64'hAAAA_BBBB_1111_2222, 32'hAAAA_BBBB);
        busy_cycles = 0;
        start_cyc = cyc;
        ireq_op(64'h8000_0004);
        check("fetch_latency", 64'(done_cyc - start_cyc), 64'd1);
        check("fetch_busy_cycles", 64'(busy_cycles), 64'd1);
        @(negedge clk);
        check("idle_after_fetch", {63'h0, creq_valid}, 64'h0);
        @(posedge clk); #1;

        // Simultaneous requests: data write first, fetch after one idle cycle.
        push_d(64'h8000_1000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 64'hDEAD_0000_0000_BEEF);
        push_i(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 32'h89AB_CDEF);
        fork
            dreq_op(64'h8000_1000, 3'd3, 8'hFF, 64'h1122_3344_5566_7788);
            ireq_op(64'h8000_0000);
        join
        check("fetch_gap_after_data", 64'(last_gap), 64'd2);
        repeat (2) @(posedge clk);
        #1;

        // Starvation bound: four data grants, then the waiting fetch, then the last data.
        for (int i = 0; i < 4; i++)
            push_d(64'h100 + 64'(8 * i), 3'd3, 8'h00, 64'h0, 64'h1000 + 64'(i));
        push_i(64'h8000_0008, 64'h5555_6666_7777_8888, 32'h7777_8888);
        push_d(64'h120, 3'd3, 8'h00, 64'h0, 64'h1004);
        fork
            begin
                for (int i = 0; i < 5; i++)
                    dreq_op(64'h100 + 64'(8 * i), 3'd3, 8'h00, 64'h0);
            end
            ireq_op(64'h8000_0008);
        join
        check("streak_after_fetch", {60'h0, dut.r_streak}, 64'h0);
        check("data_gap_after_fetch", 64'(last_gap), 64'd2);
        repeat (2) @(posedge clk);
        #1;

        // Multi-beat: three non-final beats, single completion on the last.
        n_partial = 3;
        busy_cycles = 0;
        push_d(64'h200, 3'd2, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678);
        dreq_op(64'h200, 3'd2, 8'h00, 64'h0);
        check("multibeat_busy_cycles", 64'(busy_cycles), 64'd4);
        n_partial = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset arriving with the final beat drops the response.
        q_creq.push_back('{w: 1'b0, size: 3'd3, addr: 64'h300, strb: 8'h00, wdata: 64'h0});
        q_rsp.push_back(64'h5A5A_5A5A_5A5A_5A5A);
        dreq_valid = 1'b1; dreq_addr = 64'h300; dreq_size = 3'd3; dreq_strobe = 8'h00; dreq_data = 0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0010;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!creq_valid && n < 10);
        check("rst_test_busy", {63'h0, creq_valid}, 64'h1);
        reset = 1'b1;
        dreq_valid = 1'b0;
        ireq_valid = 1'b0;
        @(negedge clk);
        check("streak_before_reset", {60'h0, dut.r_streak}, 64'h1);
        check("rst_busy_no_ok", {62'h0, iresp_data_ok, dresp_data_ok}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_idle", {63'h0, creq_valid}, 64'h0);
        check("rst_busy_streak", {60'h0, dut.r_streak}, 64'h0);
        @(posedge clk); #1;

`ifdef CBUS_ARB_STAT_EN
        push_i(64'h1000, 64'h1111_1111_2222_2222, 32'h2222_2222);
        push_d(64'h2000, 3'd2, 8'h0F, 64'hAB, 64'h0);
        push_i(64'h1004, 64'h3333_3333_4444_4444, 32'h3333_3333);
        push_d(64'h2008, 3'd3, 8'h00, 64'h0, 64'h7777);
        push_i(64'h1008, 64'h5555_5555_6666_6666, 32'h6666_6666);
        ireq_op(64'h1000);
        dreq_op(64'h2000, 3'd2, 8'h0F, 64'hAB);
        ireq_op(64'h1004);
        dreq_op(64'h2008, 3'd3, 8'h00, 64'h0);
        ireq_op(64'h1008);
        @(negedge clk);
        check("stat_igrant", {32'h0, stat_igrant}, 64'd3);
        check("stat_dgrant", {32'h0, stat_dgrant}, 64'd2);
        check("stat_iwait", {32'h0, stat_iwait}, 64'd3);
        @(posedge clk); #1;
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("exp_queue_drained", 64'(q_exp.size()), 64'd0);
        check("creq_queue_drained", 64'(q_creq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares the single unified memory port (cbus) between the pipeline's instruction-fetch port (ibus) and memory-stage data port (dbus).
- Sits between the core and the memory/cache interface.
- Serialises transactions, latches the winning request, routes responses back, and enforces a fetch-starvation bound.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (1..15).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  in  1  fetch request valid
ireq_addr  in  64  fetch address
iresp_addr_ok  out  1  fetch request accepted
iresp_data_ok  out  1  fetch data valid
iresp_data  out  32  instruction word
dreq_valid  in  1  data request valid
dreq_addr  in  64  data address
dreq_size  in  3  access size (log2 bytes)
dreq_strobe  in  8  byte write strobe; zero means read
dreq_data  in  64  write data
dresp_addr_ok  out  1  data request accepted
dresp_data_ok  out  1  data response valid
dresp_data  out  64  read data
creq_valid  out  1  cbus request valid
creq_is_write  out  1  write transaction
creq_size  out  3  access size
creq_addr  out  64  address
creq_strobe  out  8  byte strobe
creq_data  out  64  write data
cresp_ready  in  1  beat completed
cresp_last  in  1  final beat
cresp_data  in  64  read data

Behaviour:
- Clock is clk; reset is reset, synchronous, active-high.
- FSM states: IDLE, BUSY. Reset: state=IDLE, owner=NONE, streak=0, all outputs 0.
- IDLE grant decision, evaluated combinationally on the current cycle's valids:
  - Data has priority.
  - Exception: fetch wins when ireq_valid=1 and streak>=MAX_DSTREAK.
  - On grant: latch addr, size, strobe and data into a request register. Fetch grants use size=3'b010 and strobe=0. Go to BUSY next cycle.
- BUSY:
  - creq_* driven only from the latched register.
  - creq_valid=1; creq_is_write=(latched strobe!=0).
  - Latched request is held stable until completion.
- Completion occurs when cresp_ready&&cresp_last in BUSY. In that same cycle:
  - The owner's addr_ok and data_ok are asserted for exactly one cycle (combinational from cresp).
  - Data is routed to the owner. iresp_data = latched addr[2] ? cresp_data[63:32] : cresp_data[31:0].
  - Next state is IDLE.
- cresp_ready without cresp_last: beat ignored, remain BUSY.
- Latency:
  - Minimum latency is 2 cycles from request valid to data_ok (grant cycle + 1 cbus cycle).
  - After completion, IDLE lasts 1 cycle; back-to-back grants are therefore separated by one idle cycle.
- Streak counter:
  - Data grant while ireq_valid=1: streak+1, saturating at 15.
  - Fetch grant, or data grant with ireq_valid=0: streak=0.
- Requesters hold valid and payload until their data_ok. Deasserting valid while owner is BUSY does not abort the transaction; completion is still signalled.
- The non-owner sees addr_ok=data_ok=0 throughout.
- Reset mid-BUSY: next cycle is IDLE with creq_valid=0. The in-flight response is dropped and no data_ok is issued.
- Simultaneous completion and new requests: the new grant happens only in the following IDLE cycle, never in the completion cycle.

Optional Feature:
CBUS_ARB_STAT_EN
- Defined: adds outputs stat_igrant, stat_dgrant and stat_iwait, each 32-bit.
  - stat_igrant counts fetch grants; stat_dgrant counts data grants.
  - stat_iwait counts cycles with ireq_valid=1 and no fetch data_ok.
  - All three wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; arbitration is identical.

Test Plan:
- Fetch only, addr=0x8000_0004, cresp on first BUSY cycle with data 0xAAAA_BBBB_1111_2222 -> creq_valid 1 cycle, iresp_data_ok pulse 2 cycles after request, iresp_data=0xAAAA_BBBB.
- ireq and dreq valid in the same cycle, dreq write addr=0x8000_1000 strobe=0xFF -> data granted first with creq_is_write=1; fetch is granted after dresp_data_ok plus 1 idle cycle.
- Fetch held valid while data requests are continuously valid, MAX_DSTREAK=4 -> exactly 4 data grants, then the 5th grant goes to fetch, then streak=0.
- cresp_ready=1 with cresp_last=0 for 3 cycles, then last -> a single data_ok only on the last cycle; creq payload stable in every BUSY cycle.
- Assert reset during BUSY, then cresp_ready&&last arrives -> no data_ok, creq_valid=0, state IDLE, streak=0.
- With CBUS_ARB_STAT_EN: 3 fetches and 2 data accesses -> stat_igrant=3, stat_dgrant=2.
